test_harness_ctrl: RTL and testbench

TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

---
 rtl/test_harness_ctrl.sv | 121 ++++++++++++
 tb/tb_test_harness_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_harness_ctrl.sv
// Test harness controller: sequences core reset, watches the tohost
// mailbox, pc progress and a cycle budget, and reports a terminal verdict.
module test_harness_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     RST_CYCLES  = 4,
  parameter int unsigned     MAX_CYCLES  = 1000,
  parameter int unsigned     HANG_CYCLES = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h0000_0FFC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             core_rst_n,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned RST_EFF  = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
  localparam int unsigned MAX_EFF  = (MAX_CYCLES == 0) ? 1 : MAX_CYCLES;
  localparam int unsigned HANG_EFF = (HANG_CYCLES == 0) ? 1 : HANG_CYCLES;
  localparam int HOLD_W = (RST_EFF > 1) ? $clog2(RST_EFF) : 1;
  localparam int HANG_W = $clog2(HANG_EFF + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_EFF - 1);
  localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_EFF - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(MAX_EFF - 1);

  typedef enum logic [2:0] {
    S_HOLD, S_RUN, S_PASS, S_FAIL, S_TMO, S_HANG
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HANG_W-1:0] hang_cnt;
  logic [HANG_W-1:0] hang_inc;
  logic [XLEN-1:0]   prev_pc;
  logic              prev_vld;
  logic [CNT_W-1:0]  cyc_nxt;
  logic              mbox;
  logic              pc_eq;
  logic              pc_new;
  logic              hang_hit;
  logic              tmo_hit;

  assign mbox     = mem_we && (mem_addr == TOHOST_ADDR);
  assign pc_eq    = prev_vld && (pc == prev_pc);
  assign pc_new   = prev_vld && (pc != prev_pc);
  assign hang_inc = hang_cnt + 1'b1;
  assign hang_hit = pc_eq && (hang_inc >= HANG_LAST);
  assign cyc_nxt  = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  assign tmo_hit  = cyc_nxt >= TMO_LAST;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HOLD;
    else     state <= state_nxt;
  end

  // Next state: mailbox beats hang, hang beats timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      S_RUN: begin
        if (mbox)
          state_nxt = (mem_wdata == XLEN'(1)) ? S_PASS : S_FAIL;
        else if (hang_hit)
          state_nxt = S_HANG;
        else if (tmo_hit)
          state_nxt = S_TMO;
      end
      default: state_nxt = state;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    core_rst_n = (state != S_HOLD);
    pass       = (state == S_PASS);
    fail       = (state == S_FAIL);
    timeout    = (state == S_TMO);
    hang       = (state == S_HANG);
    done       = pass | fail | timeout | hang;
  end

  // Counters and captures; frozen outside HOLD/RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= '0;
      hang_cnt    <= '0;
      prev_pc     <= '0;
      prev_vld    <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
      fail_code   <= '0;
    end else if (state == S_HOLD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else if (state == S_RUN) begin
      cycle_count <= cyc_nxt;
      prev_pc     <= pc;
      prev_vld    <= 1'b1;
      hang_cnt    <= pc_eq ? hang_inc : '0;
      if (pc_new && !(&instr_count))
        instr_count <= instr_count + 1'b1;
      if (state_nxt == S_FAIL)
        fail_code <= mem_wdata >> 1;
    end
  end

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Bench for test_harness_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_test_harness_ctrl;

  localparam int RSTC  = 4;
  localparam int MAXC  = 1000;
  localparam int HANGC = 16;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rst_n;
  logic [31:0] pc_i, addr_i, wd_i;
  logic        we_i;
  logic        done, pass, fail, timeout, hang;
  logic [31:0] fail_code, cycle_count, instr_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  test_harness_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .core_rst_n  (core_rst_n),
    .pc          (pc_i),
    .mem_we      (we_i),
    .mem_addr    (addr_i),
    .mem_wdata   (wd_i),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .hang        (hang),
    .fail_code   (fail_code),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {M_NONE, M_PASS, M_FAIL, M_TMO, M_HANG} mstat_t;
  mstat_t      m_st;
  int          m_hold;
  logic [31:0] m_pcs[$];
  logic [31:0] m_code;

  // number of trailing equal neighbours if p were appended to the trace
  function automatic int tail_repeats(input logic [31:0] p);
    int n = 0;
    for (int i = m_pcs.size() - 1; i >= 0; i--) begin
      if (m_pcs[i] != p) break;
      n++;
    end
    return n;
  endfunction

  function automatic int pc_changes();
    int n = 0;
    for (int i = 1; i < m_pcs.size(); i++)
      if (m_pcs[i] != m_pcs[i-1]) n++;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st   <= M_NONE;
      m_hold <= 0;
      m_code <= '0;
      m_pcs.delete();
    end else if (m_hold < RSTC) begin
      m_hold <= m_hold + 1;
    end else if (m_st == M_NONE) begin
      if (we_i && addr_i == TOHOST) begin
        if (wd_i == 32'd1) m_st <= M_PASS;
        else begin
          m_st   <= M_FAIL;
          m_code <= wd_i >> 1;
        end
      end else if (tail_repeats(pc_i) >= HANGC - 1)
        m_st <= M_HANG;
      else if (m_pcs.size() + 1 >= MAXC - 1)
        m_st <= M_TMO;
      m_pcs.push_back(pc_i);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_core_rst_n", 64'(core_rst_n), 64'(m_hold >= RSTC));
      chk("m_pass",       64'(pass),       64'(m_st == M_PASS));
      chk("m_fail",       64'(fail),       64'(m_st == M_FAIL));
      chk("m_timeout",    64'(timeout),    64'(m_st == M_TMO));
      chk("m_hang",       64'(hang),       64'(m_st == M_HANG));
      chk("m_done",       64'(done),       64'(m_st != M_NONE));
      chk("m_fail_code",  64'(fail_code),  64'(m_code));
      chk("m_cycle_count", 64'(cycle_count), 64'(m_pcs.size()));
      chk("m_instr_count", 64'(instr_count), 64'(pc_changes()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [31:0] p, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    pc_i = p; we_i = we; addr_i = a; wd_i = d;
    @(negedge clk);
  endtask

  // rst for two cycles, then measure how long core reset stays low
  task automatic apply_reset(input logic hold_wr);
    int low = 0;
    rst = 1'b1;
    pc_i = '0; we_i = hold_wr; addr_i = TOHOST; wd_i = 32'd1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (core_rst_n) break;
      low++;
      @(negedge clk);
    end
    chk("hold_len", 64'(low), 64'(RSTC));
    we_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst = 1'b1;
    pc_i = '0; we_i = 1'b0; addr_i = '0; wd_i = '0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_core", 64'(core_rst_n), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt",  64'(cycle_count), 64'd0);

    // pass at RUN cycle 10, stray write elsewhere ignored
    apply_reset(1'b0);
    for (int i = 0; i <= 10; i++)
      cyc(32'h100 + 32'(4*i), i == 5 || i == 10,
          (i == 5) ? 32'hFF8 : TOHOST, 32'd1);
    chk("pass_flag",  64'(pass), 64'd1);
    chk("pass_done",  64'(done), 64'd1);
    chk("pass_fail",  64'(fail), 64'd0);
    chk("pass_cycles", 64'(cycle_count), 64'd11);
    chk("pass_instr", 64'(instr_count), 64'd10);
    cyc(32'h200, 1'b1, TOHOST, 32'd7);
    cyc(32'h204, 1'b0, '0, '0);
    chk("pass_sticky", 64'({pass, fail}), 64'b10);
    chk("pass_frozen", 64'(cycle_count), 64'd11);

    // fail with code 7>>1, later pass write ignored
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(32'h100 + 32'(4*i), 1'b0, '0, '0);
    cyc(32'h10C, 1'b1, TOHOST, 32'h7);
    chk("fail_flag", 64'(fail), 64'd1);
    chk("fail_code", 64'(fail_code), 64'd3);
    cyc(32'h110, 1'b1, TOHOST, 32'd1);
    cyc(32'h114, 1'b0, '0, '0);
    chk("fail_sticky", 64'({pass, fail}), 64'b01);
    chk("fail_code_kept", 64'(fail_code), 64'd3);

    // mailbox write during hold ignored; write of 0 fails with code 0
    apply_reset(1'b1);
    for (int i = 0; i < 3; i++) cyc(32'h100 + 32'(4*i), 1'b0, '0, '0);
    chk("hold_wr_ignored", 64'(done), 64'd0);
    cyc(32'h10C, 1'b1, TOHOST, 32'h0);
    chk("fail0_flag", 64'(fail), 64'd1);
    chk("fail0_code", 64'(fail_code), 64'd0);

    // timeout
    apply_reset(1'b0);
    for (int i = 0; i < 1005; i++)
      cyc(32'h1000 + 32'(4*i), 1'b0, '0, '0);
    chk("tmo_flag",   64'(timeout), 64'd1);
    chk("tmo_cycles", 64'(cycle_count), 64'd999);
    chk("tmo_instr",  64'(instr_count), 64'd998);

    // hang: pc stuck at 0x40 from cycle 5
    apply_reset(1'b0);
    first = -1;
    for (int i = 0; i < 26; i++) begin
      cyc((i < 5) ? 32'h100 + 32'(4*i) : 32'h40, 1'b0, '0, '0);
      if (hang && first < 0) first = i;
    end
    chk("hang_cycle",  64'(first), 64'd20);
    chk("hang_cycles", 64'(cycle_count), 64'd21);
    chk("hang_instr",  64'(instr_count), 64'd5);

    // same, with pass write on the hang cycle
    apply_reset(1'b0);
    for (int i = 0; i < 24; i++)
      cyc((i < 5) ? 32'h100 + 32'(4*i) : 32'h40, i == 20, TOHOST, 32'd1);
    chk("hang_vs_pass", 64'({pass, hang}), 64'b10);

    // hang and timeout on the same edge
    apply_reset(1'b0);
    for (int i = 0; i < 1003; i++)
      cyc((i < 983) ? 32'h1000 + 32'(4*i) : 32'h40, 1'b0, '0, '0);
    chk("hang_vs_tmo", 64'({hang, timeout}), 64'b10);
    chk("hang_tmo_cycles", 64'(cycle_count), 64'd999);
    chk("hang_tmo_instr",  64'(instr_count), 64'd983);

    // asynchronous reset in the middle of RUN
    apply_reset(1'b0);
    for (int i = 0; i < 50; i++) cyc(32'h100 + 32'(4*i), 1'b0, '0, '0);
    chk("pre_abort_cycles", 64'(cycle_count), 64'd50);
    #3 rst = 1'b1;
    #1;
    chk("abort_core",  64'(core_rst_n), 64'd0);
    chk("abort_stat",  64'({done, pass, fail, timeout, hang}), 64'd0);
    chk("abort_cnts",  64'({cycle_count, instr_count}), 64'd0);
    @(negedge clk);
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(32'h300 + 32'(4*i), 1'b0, '0, '0);
    chk("restart_cycles", 64'(cycle_count), 64'd3);
    chk("restart_instr",  64'(instr_count), 64'd2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
